// File: rtl/vga_scanout.sv
// VGA raster timing generator and pin driver: counters out to the renderers, colour/sync
// realigned through a PIPE-deep delay line. Optional colour bars under SCANOUT_TESTPATTERN_EN.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE     = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       active,
  output logic       frame_start,
  input  logic [3:0] rgb_in,
  input  logic       test_pattern,
  output logic [3:0] vga_rgb,
  output logic       vga_hsync,
  output logic       vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync_raw;
  logic       vsync_raw;

  // No handshake: renderers see pixel_x/pixel_y every cycle and must return rgb_in exactly
  // PIPE cycles later; there is no valid/ready and no backpressure in either direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  assign pixel_x     = hcount;
  assign pixel_y     = vcount;
  assign active      = (hcount < H_ACT) && (vcount < V_ACT);
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign hsync_raw   = !((hcount >= HS_START) && (hcount < HS_END));
  assign vsync_raw   = !((vcount >= VS_START) && (vcount < VS_END));

  // Stage i holds the value the counters produced i cycles ago.
  logic [PIPE:1] act_d;
  logic [PIPE:1] hs_d;
  logic [PIPE:1] vs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      act_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
    end else begin
      act_d[1] <= active;
      hs_d[1]  <= hsync_raw;
      vs_d[1]  <= vsync_raw;
      for (int i = 2; i <= PIPE; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
    end
  end

  logic [3:0] colour_src;

`ifdef SCANOUT_TESTPATTERN_EN
  logic [2:0]    bar_k;
  logic [3:0]    bar_colour;
  logic [PIPE:1] tp_d;
  logic [3:0]    bar_d [PIPE:1];

  // Out-of-range k only occurs in blanking, where the colour is discarded.
  assign bar_k = 3'(hcount / 10'd80);

  always_comb begin
    bar_colour = 4'b0000;
    case (bar_k)
      3'd0: bar_colour = 4'b0000;
      3'd1: bar_colour = 4'b0011;
      3'd2: bar_colour = 4'b0001;
      3'd3: bar_colour = 4'b0111;
      3'd4: bar_colour = 4'b0100;
      3'd5: bar_colour = 4'b1101;
      3'd6: bar_colour = 4'b0110;
      3'd7: bar_colour = 4'b1011;
      default: bar_colour = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_d <= '0;
      for (int i = 1; i <= PIPE; i++) bar_d[i] <= 4'b0000;
    end else begin
      tp_d[1]  <= test_pattern;
      bar_d[1] <= bar_colour;
      for (int i = 2; i <= PIPE; i++) begin
        tp_d[i]  <= tp_d[i-1];
        bar_d[i] <= bar_d[i-1];
      end
    end
  end

  assign colour_src = tp_d[PIPE] ? bar_d[PIPE] : rgb_in;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign colour_src          = rgb_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb   <= 4'b0000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_rgb   <= act_d[PIPE] ? colour_src : 4'b0000;
      vga_hsync <= hs_d[PIPE];
      vga_vsync <= vs_d[PIPE];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full-width lines with a short frame height, random colour and
// test_pattern stimulus, a mid-frame reset, and a per-cycle scoreboard on every output.
module tb_vga_scanout;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 3;
  localparam int RST_CYCLES = 3;
  localparam int RST_AT = RST_CYCLES + FRAME + 2 * HT + 300;
  localparam int TOTAL = RST_AT + 2 * FRAME + 500;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       active, frame_start;
  logic [3:0] rgb_in;
  logic       test_pattern;
  logic [3:0] vga_rgb;
  logic       vga_hsync, vga_vsync;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE(2)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .active(active), .frame_start(frame_start), .rgb_in(rgb_in),
    .test_pattern(test_pattern), .vga_rgb(vga_rgb),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  // Clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] tag;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic        fs;
    logic [3:0]  rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   fail_prints = 0;
  logic [3:0] bar_tab [8] = '{4'b0000, 4'b0011, 4'b0001, 4'b0111,
                              4'b0100, 4'b1101, 4'b0110, 4'b1011};

  // Reference model: raster position from cycles elapsed since reset release.
  function automatic int xpos(int n); return n % HT; endfunction
  function automatic int ypos(int n); return (n / HT) % VT; endfunction
  function automatic logic vis(int n);
    return (xpos(n) < HA) && (ypos(n) < VA);
  endfunction
  function automatic logic hs_n(int n);
    return !((xpos(n) >= HA + HF) && (xpos(n) < HA + HF + HS));
  endfunction
  function automatic logic vs_n(int n);
    return !((ypos(n) >= VA + VF) && (ypos(n) < VA + VF + VS));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else if (fail_prints < 40) begin
      fail_prints++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the expectation tagged for this cycle and compares every output.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].tag == 32'(cyc)) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pixel_x",     32'(pixel_x),     32'(e.x));
      chk("pixel_y",     32'(pixel_y),     32'(e.y));
      chk("active",      32'(active),      32'(e.act));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("vga_rgb",     32'(vga_rgb),     32'(e.rgb));
      chk("vga_hsync",   32'(vga_hsync),   32'(e.hs));
      chk("vga_vsync",   32'(vga_vsync),   32'(e.vs));
    end
  end

  // Driver: drives inputs for the current cycle, pushes the expectation for the next one.
  initial begin
    int   n;
    logic r;
    logic tp_cur;
    logic tp_hist [4];
    logic [3:0] col;
    exp_t e;
    reset = 1'b1;
    rgb_in = 4'b0000;
    test_pattern = 1'b0;
    tp_cur = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) tp_hist[i] = 1'b0;

    for (int c = 0; c < TOTAL; c++) begin
      @(posedge clk);
      #1;
      r = (c < RST_CYCLES) || (c == RST_AT);
      if ($urandom_range(0, 99) == 0) tp_cur = 1'(($urandom_range(0, 1)));
      // First frame emulates a renderer returning x[3:0], 1111 in blanking; later random.
      if (c < RST_CYCLES + FRAME) begin
        if (n >= 2 && vis(n - 2)) col = 4'(xpos(n - 2));
        else col = 4'b1111;
      end else begin
        col = 4'($urandom_range(0, 15));
      end
      reset = r;
      rgb_in = col;
      test_pattern = tp_cur;
      tp_hist[n % 4] = tp_cur;

      e.tag = 32'(cyc + 1);
      if (r) begin
        e.x = '0; e.y = '0; e.act = 1'b1; e.fs = 1'b1;
        e.rgb = 4'b0000; e.hs = 1'b1; e.vs = 1'b1;
        n = 0;
      end else begin
        e.x   = 10'(xpos(n + 1));
        e.y   = 10'(ypos(n + 1));
        e.act = vis(n + 1);
        e.fs  = (xpos(n + 1) == 0) && (ypos(n + 1) == 0);
        // Pins in cycle n+1 show the raster position n+1-LAT.
        if (n + 1 >= LAT) begin
          e.hs = hs_n(n + 1 - LAT);
          e.vs = vs_n(n + 1 - LAT);
          if (!vis(n + 1 - LAT)) e.rgb = 4'b0000;
`ifdef SCANOUT_TESTPATTERN_EN
          else if (tp_hist[(n + 1 - LAT) % 4]) e.rgb = bar_tab[xpos(n + 1 - LAT) / 80];
`endif
          else e.rgb = col;
        end else begin
          e.rgb = 4'b0000; e.hs = 1'b1; e.vs = 1'b1;
        end
        n++;
      end
      exp_q.push_back(e);
    end

    reset = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() > 1) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, expected at most 1", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
